// File: rtl/md5_pipeline.sv
// md5_pipeline: fully unrolled 64-stage MD5 over one padded block holding a 1..16 byte guess.
// Latency 65 edges from input sample to hash outputs; one guess per clock, no stalls.
// No backpressure; defining MD5_VALID_EN adds in_valid/out_valid qualifiers.
module md5_pipeline (
    input  logic         clk,
    input  logic         rst_n,
`ifdef MD5_VALID_EN
    input  logic         in_valid,
    output logic         out_valid,
`endif
    input  logic [127:0] guess,
    input  logic [3:0]   guesslen,
    output logic [31:0]  hashA,
    output logic [31:0]  hashB,
    output logic [31:0]  hashC,
    output logic [31:0]  hashD
);

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] K [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam int S [0:15] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    // Padded block word j, little-endian bytes; bytes past the length never reach the block.
    function automatic logic [31:0] msg_word(input logic [127:0] g, input logic [3:0] len, input int j);
        logic [31:0] w;
        int          l;
        int          k;
        w = '0;
        l = int'(len) + 1;
        for (int b = 0; b < 4; b++) begin
            k = 4 * j + b;
            if (k < l) begin
                w[8*b +: 8] = g[127 - 8*(k % 16) -: 8];
            end else if (k == l) begin
                w[8*b +: 8] = 8'h80;
            end
        end
        if (j == 14) begin
            w = 32'(l) << 3;
        end
        return w;
    endfunction

    // Returns the next {A,B,C,D} after MD5 round i.
    function automatic logic [127:0] md5_round(input int i,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic [31:0] d,
                                               input logic [127:0] g, input logic [3:0] len);
        logic [31:0] f;
        logic [31:0] t;
        logic [31:0] r;
        int          gi;
        int          idx;
        int          s;
        case (i / 16)
            0: begin f = (b & c) | (~b & d); gi = i;                end
            1: begin f = (d & b) | (~d & c); gi = (5 * i + 1) % 16; end
            2: begin f = b ^ c ^ d;          gi = (3 * i + 5) % 16; end
            default: begin f = c ^ (b | ~d); gi = (7 * i) % 16;    end
        endcase
        idx = 4 * (i / 16) + (i % 4);
        s   = S[idx[3:0]];
        t   = a + f + K[i[5:0]] + msg_word(g, len, gi);
        r   = (t << s) | (t >> (32 - s));
        return {d, b + r, b, c};
    endfunction

    logic [63:0][31:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [62:0][127:0] guess_q, guess_d;
    logic [62:0][3:0]   len_q, len_d;
    logic [63:0]        vld_q, vld_d;
    logic [31:0]        hash_a_q, hash_a_d, hash_b_q, hash_b_d;
    logic [31:0]        hash_c_q, hash_c_d, hash_d_q, hash_d_d;
    logic               in_vld;

`ifdef MD5_VALID_EN
    logic out_vld_q, out_vld_d;
    assign in_vld    = in_valid;
    assign out_valid = out_vld_q;
`else
    assign in_vld = 1'b1;
`endif

    assign {a_d[0], b_d[0], c_d[0], d_d[0]} = md5_round(0, IV_A, IV_B, IV_C, IV_D, guess, guesslen);

    for (genvar i = 1; i < 64; i++) begin : g_stage
        assign {a_d[i], b_d[i], c_d[i], d_d[i]} =
            md5_round(i, a_q[i-1], b_q[i-1], c_q[i-1], d_q[i-1], guess_q[i-1], len_q[i-1]);
    end

    always_comb begin
        guess_d  = {guess_q[61:0], guess};
        len_d    = {len_q[61:0], guesslen};
        vld_d    = {vld_q[62:0], in_vld};
        hash_a_d = hash_a_q;
        hash_b_d = hash_b_q;
        hash_c_d = hash_c_q;
        hash_d_d = hash_d_q;
        if (vld_q[63]) begin
            hash_a_d = IV_A + a_q[63];
            hash_b_d = IV_B + b_q[63];
            hash_c_d = IV_C + c_q[63];
            hash_d_d = IV_D + d_q[63];
        end
`ifdef MD5_VALID_EN
        out_vld_d = vld_q[63];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            guess_q  <= '0;
            len_q    <= '0;
            vld_q    <= '0;
            hash_a_q <= '0;
            hash_b_q <= '0;
            hash_c_q <= '0;
            hash_d_q <= '0;
`ifdef MD5_VALID_EN
            out_vld_q <= 1'b0;
`endif
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            guess_q  <= guess_d;
            len_q    <= len_d;
            vld_q    <= vld_d;
            hash_a_q <= hash_a_d;
            hash_b_q <= hash_b_d;
            hash_c_q <= hash_c_d;
            hash_d_q <= hash_d_d;
`ifdef MD5_VALID_EN
            out_vld_q <= out_vld_d;
`endif
        end
    end

    assign hashA = hash_a_q;
    assign hashB = hash_b_q;
    assign hashC = hash_c_q;
    assign hashD = hash_d_q;

endmodule

// File: tb/tb_md5_pipeline.sv
// Scoreboard bench for md5_pipeline: directed guesses with known digests, reset flush checks.
module tb_md5_pipeline;

    localparam logic [127:0] G_ABCD  = 128'h61626364_00000000_00000000_00000000;
    localparam logic [127:0] G_A     = 128'h61000000_00000000_00000000_00000000;
    localparam logic [127:0] G_AJUNK = 128'h61ffffff_ffffffff_ffffffff_ffffffff;
    localparam logic [127:0] D_ABCD  = 128'h4c71fce2_93ee2747_cd24f395_1f337f2e;
    localparam logic [127:0] D_ABC   = 128'h98500190_b04fd23c_7d3f96d6_727fe128;
    localparam logic [127:0] D_A     = 128'hb975c10c_a8b6f1c0_e299c331_61267769;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] guess;
    logic [3:0]   guesslen;
    logic [31:0]  hashA, hashB, hashC, hashD;
`ifdef MD5_VALID_EN
    logic         in_valid;
    logic         out_valid;
`endif

    always #5 clk = ~clk;

    md5_pipeline dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef MD5_VALID_EN
        .in_valid (in_valid),
        .out_valid(out_valid),
`endif
        .guess    (guess),
        .guesslen (guesslen),
        .hashA    (hashA),
        .hashB    (hashB),
        .hashC    (hashC),
        .hashD    (hashD)
    );

    typedef struct {
        int           due;
        logic [127:0] dig;
        int           tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   edge_n  = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    always @(posedge clk) edge_n++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_n);
    endtask

    // Call between edges: the guess is sampled on the next rising edge.
    task automatic issue(input logic [127:0] g, input logic [3:0] l, input bit push,
                         input logic [127:0] dig, input int tag);
        guess    = g;
        guesslen = l;
        if (push) sb.push_back('{due: edge_n + 65, dig: dig, tag: tag});
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expected digests never seen, required 0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= edge_n) begin
            mon_e = sb.pop_front();
            check($sformatf("digest%0d", mon_e.tag), {hashA, hashB, hashC, hashD}, mon_e.dig);
`ifdef MD5_VALID_EN
            check($sformatf("out_valid%0d", mon_e.tag), {127'd0, out_valid}, 128'd1);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, r;
`ifdef MD5_VALID_EN
        int p;
        in_valid = 1'b1;
`endif
        rst_n    = 1'b0;
        guess    = '0;
        guesslen = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_zero", {hashA, hashB, hashC, hashD}, '0);

        // First entry on the first edge with rst_n=1, then back-to-back "a","abc","abcd".
        rst_n = 1'b1;
        t0 = edge_n + 1;
        issue(G_ABCD, 4'd3, 1'b1, D_ABCD, 0);
        @(posedge clk); #1; issue(G_A,     4'd0, 1'b1, D_A,    1);
        @(posedge clk); #1; issue(G_ABCD,  4'd2, 1'b1, D_ABC,  2);
        @(posedge clk); #1; issue(G_ABCD,  4'd3, 1'b1, D_ABCD, 3);
        @(posedge clk); #1; issue(G_AJUNK, 4'd0, 1'b1, D_A,    4);
        @(posedge clk); #1; issue('0,      4'd0, 1'b0, '0,     0);
        while (edge_n < t0 + 63) begin
            @(negedge clk);
            check("zero_before_first", {hashA, hashB, hashC, hashD}, '0);
        end
        wait_drain();

        // Reset 30 edges into a stream: flush everything, then a fresh "a".
        for (int k = 0; k < 30; k++) begin
            issue(G_ABCD, 4'd3, 1'b0, '0, 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        r = edge_n + 1;
        issue(G_A, 4'd0, 1'b1, D_A, 5);
        while (edge_n < r + 63) begin
            @(negedge clk);
            check("no_stale_after_reset", {hashA, hashB, hashC, hashD}, '0);
        end
        wait_drain();

`ifdef MD5_VALID_EN
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        check("idle_out_valid", {127'd0, out_valid}, 128'd0);
        in_valid = 1'b1;
        p = edge_n + 1;
        issue(G_ABCD, 4'd3, 1'b1, D_ABCD, 6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        guess    = G_AJUNK;
        while (edge_n < p + 70) begin
            @(negedge clk);
            check("pulse_out_valid", {127'd0, out_valid}, {127'd0, edge_n == p + 64});
            if (edge_n < p + 64) check("hold_prev", {hashA, hashB, hashC, hashD}, D_A);
            else check("hold_abcd", {hashA, hashB, hashC, hashD}, D_ABCD);
        end
        wait_drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
